// File: rtl/alu_op_seq_pkg.sv
// Shared types and widths for the ALU opcode sequencer.
package alu_op_seq_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned A_W       = 4;
  localparam int unsigned DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [A_W-1:0]  a;
  } entry_t;

endpackage

// File: rtl/alu_op_seq_seq_buf.sv
// Program storage: DEPTH-entry register file, one write port, one registered read port.
// A write to the address being read in the same cycle is forwarded to the read register.
module seq_buf
  import alu_op_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [DEPTH];
  entry_t rdata_q;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[raddr == waddr ? waddr : waddr] <= wdata;
  end

  // Registered read with write-first forwarding.
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) rdata_q <= wdata;
    else                        rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/alu_op_seq.sv
// ALU opcode sequencer: loads a small program, then issues it entry by entry over a
// valid/ready handshake. Optional feature macro: ALU_OP_SEQ_LOOP_EN (adds port stop and
// makes RUN loop over the program until stopped).
module alu_op_seq
  import alu_op_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [OP_W-1:0] load_op,
  input  logic [A_W-1:0]  load_a,
  input  logic            clr,
  input  logic            start,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [OP_W-1:0] issue_op,
  output logic [A_W-1:0]  issue_a,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [4:0]      count
`ifdef ALU_OP_SEQ_LOOP_EN
  ,
  input  logic            stop
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL  = 5'(DEPTH);

  state_e           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             load_fire, issue_fire, last;
  logic [4:0]       count_after;
  entry_t           rd_entry;
`ifdef ALU_OP_SEQ_LOOP_EN
  logic             wrap_q, wrap_d;
`endif

  // clr wins over a same-cycle load; a load alongside start counts toward the run.
  assign load_fire   = load_ready & load_valid & ~clr;
  assign count_after = count_q + {4'd0, load_fire};
  assign issue_fire  = (state_q == StRun) & issue_ready;
  assign last        = (5'(ptr_q) == (count_q - 5'd1));

  // State register and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
`ifdef ALU_OP_SEQ_LOOP_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
`ifdef ALU_OP_SEQ_LOOP_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!clr && start) begin
          if (count_after == 5'd0) err_d   = 1'b1;
          else                     state_d = StRun;
        end
      end
      StRun: begin
`ifdef ALU_OP_SEQ_LOOP_EN
        if (stop) state_d = StDone;
`else
        if (issue_fire && last) state_d = StDone;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Entry count and issue pointer; the pointer sits at 0 outside RUN so entry 0 is
  // already in the read register when RUN begins.
  always_comb begin
    count_d = count_q;
    ptr_d   = '0;
    if (state_q == StIdle) begin
      if (clr)            count_d = '0;
      else if (load_fire) count_d = count_q + 5'd1;
    end
    if (state_q == StRun) begin
      ptr_d = ptr_q;
      if (issue_fire) ptr_d = last ? '0 : ptr_q + PTR_W'(1);
    end
  end

`ifdef ALU_OP_SEQ_LOOP_EN
  // Wrap marker drives the per-pass done pulse while looping.
  always_comb begin
    wrap_d = issue_fire & last & ~stop;
  end
`endif

  // Moore outputs.
  always_comb begin
    load_ready  = (state_q == StIdle) && (count_q < FULL);
    issue_valid = (state_q == StRun);
    issue_op    = issue_valid ? rd_entry.op : '0;
    issue_a     = issue_valid ? rd_entry.a  : '0;
    busy        = (state_q == StRun) || (state_q == StDone);
    done        = (state_q == StDone);
`ifdef ALU_OP_SEQ_LOOP_EN
    done        = done | wrap_q;
`endif
    err         = err_q;
    count       = count_q;
  end

  seq_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (load_fire),
    .waddr (count_q[PTR_W-1:0]),
    .wdata ('{op: load_op, a: load_a}),
    .raddr (ptr_d),
    .rdata (rd_entry)
  );

endmodule

// File: tb/tb_alu_op_seq.sv
// Directed self-checking bench for alu_op_seq (default DEPTH=8).
module tb_alu_op_seq;

  logic       clk = 1'b0;
  logic       reset_n, load_valid, load_ready, clr, start;
  logic [2:0] load_op, issue_op;
  logic [3:0] load_a, issue_a;
  logic       issue_valid, issue_ready, busy, done, err;
  logic [4:0] count;
`ifdef ALU_OP_SEQ_LOOP_EN
  logic       stop = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_op_seq #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_op     (load_op),
    .load_a      (load_a),
    .clr         (clr),
    .start       (start),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_a     (issue_a),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .count       (count)
`ifdef ALU_OP_SEQ_LOOP_EN
    ,
    .stop        (stop)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] op, input logic [3:0] a);
    load_valid = 1'b1;
    load_op    = op;
    load_a     = a;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // {issue_valid, issue_op, issue_a}
  function automatic logic [7:0] iss(input logic v, input logic [2:0] op, input logic [3:0] a);
    return {v, op, a};
  endfunction

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_op = '0; load_a = '0;
    clr = 1'b0; start = 1'b0; issue_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check_eq("rst_count", count, 0);
    check_eq("rst_ready", load_ready, 1);
    check_eq("rst_issue", iss(issue_valid, issue_op, issue_a), 0);
    check_eq("rst_flags", {busy, done, err}, 0);

    // Start with empty buffer: one-cycle err, stays idle
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("empty_err", {err, busy, issue_valid}, 3'b100);
    step();
    check_eq("empty_err_clr", {err, busy}, 0);

    // Three entries, back-to-back issue
    load(3'b000, 4'd1);
    load(3'b001, 4'd2);
    load(3'b111, 4'd3);
    check_eq("cnt3", count, 3);
    issue_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("run3_e0", iss(issue_valid, issue_op, issue_a), iss(1, 3'b000, 4'd1));
    check_eq("run3_busy", busy, 1);
    step();
    check_eq("run3_e1", iss(issue_valid, issue_op, issue_a), iss(1, 3'b001, 4'd2));
    step();
    check_eq("run3_e2", iss(issue_valid, issue_op, issue_a), iss(1, 3'b111, 4'd3));
    step();
    check_eq("run3_done", {issue_valid, done, busy}, 3'b011);
    check_eq("run3_done_iss0", {issue_op, issue_a}, 0);
    step();
    check_eq("run3_idle", {done, busy}, 0);
    check_eq("run3_keep", count, 3);

    // Replay; clr/load/start during RUN are ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("replay_e0", iss(issue_valid, issue_op, issue_a), iss(1, 3'b000, 4'd1));
    clr = 1'b1; load_valid = 1'b1; load_op = 3'd6; load_a = 4'd9; start = 1'b1;
    step();
    check_eq("replay_e1", iss(issue_valid, issue_op, issue_a), iss(1, 3'b001, 4'd2));
    step();
    check_eq("replay_e2", iss(issue_valid, issue_op, issue_a), iss(1, 3'b111, 4'd3));
    clr = 1'b0; load_valid = 1'b0; start = 1'b0;
    step();
    check_eq("replay_done", {done, count}, {1'b1, 5'd3});
    step();

    // clr beats simultaneous load and start
    clr = 1'b1; load_valid = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; load_valid = 1'b0; start = 1'b0;
    check_eq("clr_prio", {count, busy, err}, 0);

    // Fill past DEPTH; ninth entry dropped
    for (int i = 0; i < 9; i++) load(3'(i), 4'(15 - i));
    check_eq("full_cnt", count, 8);
    check_eq("full_ready", load_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("full_e%0d", i), iss(issue_valid, issue_op, issue_a),
               iss(1, 3'(i), 4'(15 - i)));
      step();
    end
    check_eq("full_done", {done, issue_valid}, 2'b10);
    step();
    do_clr();

    // Back-pressure: entry 0 held for three cycles
    load(3'd2, 4'd5);
    load(3'd4, 4'd9);
    issue_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stall_e0_%0d", i), iss(issue_valid, issue_op, issue_a),
               iss(1, 3'd2, 4'd5));
      if (i < 2) step();
    end
    issue_ready = 1'b1;
    step();
    check_eq("stall_e1", iss(issue_valid, issue_op, issue_a), iss(1, 3'd4, 4'd9));
    step();
    check_eq("stall_done", done, 1);
    step();
    do_clr();

    // Reset mid-run after one entry issued
    for (int i = 0; i < 4; i++) load(3'(i + 1), 4'(i + 4));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("mid_e1", iss(issue_valid, issue_op, issue_a), iss(1, 3'd2, 4'd5));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_eq("mid_rst", {count, issue_valid, done, busy, load_ready}, {5'd0, 4'b0001});

    // Load and start together on an empty buffer
    load_valid = 1'b1; load_op = 3'd5; load_a = 4'd6; start = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b0;
    check_eq("ldst_e0", iss(issue_valid, issue_op, issue_a), iss(1, 3'd5, 4'd6));
    check_eq("ldst_cnt", count, 1);
    step();
    check_eq("ldst_done", done, 1);
    step();

`ifdef ALU_OP_SEQ_LOOP_EN
    do_clr();
    load(3'd1, 4'd1);
    load(3'd2, 4'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("loop_%0d", i), {iss(issue_valid, issue_op, issue_a), done},
               {iss(1, 3'(1 + i % 2), 4'(1 + i % 2)), (i == 2 || i == 4)});
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("loop_stop", {issue_valid, busy, done}, 3'b011);
    step();
    check_eq("loop_idle", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_seq.md
ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, 8, number of program entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port load_valid  input  1  program-entry write request.
REQ-005 The block SHALL have port load_ready  output  1  entry can be accepted this cycle.
REQ-006 The block SHALL have port load_op  input  3  ALU opcode for the entry.
REQ-007 The block SHALL have port load_a  input  4  ALU operand A for the entry.
REQ-008 The block SHALL have port clr  input  1  empty the program buffer; honoured in IDLE only.
REQ-009 The block SHALL have port start  input  1  begin issuing the stored program.
REQ-010 The block SHALL have port issue_valid  output  1  issue_op/issue_a are valid.
REQ-011 The block SHALL have port issue_ready  input  1  downstream ALU/accumulator stage accepts the entry.
REQ-012 The block SHALL have port issue_op  output  3  opcode to the ALU stage.
REQ-013 The block SHALL have port issue_a  output  4  operand A to the ALU stage.
REQ-014 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at program completion.
REQ-016 The block SHALL have port err  output  1  one-cycle pulse on start with an empty buffer.
REQ-017 The block SHALL have port count  output  5  number of stored entries, 0..DEPTH.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 load_ready SHALL be 1 only in IDLE with count<DEPTH; a load handshake writes {load_op,load_a} to entry[count] and increments count next cycle.
REQ-020 load_valid with load_ready=0 (full, or RUN/DONE) SHALL be dropped with no state change.
REQ-021 clr in IDLE SHALL set count=0 next cycle and take priority over a simultaneous load and start.
REQ-022 start in IDLE with count>0 SHALL move to RUN with ptr=0; with count=0 it SHALL stay in IDLE and pulse err for one cycle.
REQ-023 Simultaneous start and load in IDLE SHALL store the entry and start with the updated count.
REQ-024 In RUN issue_valid SHALL be 1 and issue_op/issue_a SHALL equal entry[ptr], registered, stable until the handshake.
REQ-025 On issue_valid&issue_ready ptr SHALL advance by one; one entry SHALL be issued per handshake cycle, with no bubble between consecutive entries when issue_ready stays high.
REQ-026 The handshake on entry count-1 SHALL move to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-027 Outside RUN issue_valid SHALL be 0 and issue_op/issue_a SHALL hold 0.
REQ-028 start, clr and load SHALL be ignored in RUN and DONE; the stored program and count SHALL persist after DONE so start replays it.

Reset
REQ-029 reset_n=0 at a clock edge SHALL force IDLE, count=0, ptr=0, issue_valid=0, issue_op=0, issue_a=0, busy=0, done=0, err=0, load_ready=1, including mid-RUN.
REQ-030 Buffer contents need not be reset; they are unreadable while count=0.

Configuration
REQ-031 Macro ALU_OP_SEQ_LOOP_EN SHALL, when defined, add input port stop (1 bit); in RUN the handshake on entry count-1 wraps ptr to 0, pulses done, and stays in RUN; stop, sampled in RUN, moves to DONE after the in-flight handshake or immediately if none is pending.
REQ-032 Without ALU_OP_SEQ_LOOP_EN port stop SHALL not exist and behaviour SHALL be single-pass per REQ-026.

Structure
REQ-033 Package alu_op_seq_pkg SHALL hold the state enum, OP_W=3, A_W=4, DEPTH_DEF=8, and the entry struct typedef {op, a}.
REQ-034 Storage SHALL be sub-module seq_buf (DEPTH-entry register file, one write port, one registered read port); FSM, counters and handshake stay in alu_op_seq.

Verification
REQ-035 Load 3 entries (000,1),(001,2),(111,3), start, issue_ready=1 -> issue_valid 3 consecutive cycles with those values, then done=1 for one cycle, busy=0.
REQ-036 start with count=0 -> err one cycle, state stays IDLE, issue_valid=0.
REQ-037 Load DEPTH+1 entries -> count=DEPTH, load_ready=0, extra entry dropped.
REQ-038 Run 2 entries with issue_ready low for 3 cycles on entry 0 -> issue_op/issue_a stable throughout, entry 1 issued after the handshake.
REQ-039 reset_n=0 during RUN after 1 of 4 entries -> next cycle IDLE, count=0, issue_valid=0, done=0.
REQ-040 With ALU_OP_SEQ_LOOP_EN, 2 entries, issue_ready=1 -> sequence 0,1,0,1, done pulse every 2 handshakes; stop -> DONE then IDLE.
